// File: rtl/cpu_rd_pkg.sv
// Shared types and default constants for the CPU read arbiter.
package cpu_rd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      HOLD    = 2'd2,
      RELEASE = 2'd3
   } rdState_e;

   localparam int DEF_N_REQ          = 16;
   localparam int DEF_WAIT_CYCLES    = 4;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   // Counter width able to hold maxVal, never narrower than one bit.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/cpu_rd_arbiter_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins; any flags a non-empty vector.
module prio_enc #(
   parameter int N = 16
) (
   input  logic [N-1:0]                   req,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx,
   output logic                           any
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   always_comb begin
      idx = '0;
      any = |req;
      for (int i = N - 1; i >= 0; i--)
         if (req[i]) idx = IW'(i);
   end

endmodule

// File: rtl/cpu_rd_arbiter.sv
// Z80 read-data arbiter: grants one chip select, inserts WAIT states, pulses on completion.
// Optional build macro CPU_RD_CONFLICT_LOG_EN adds the conflict_sticky output.
module cpu_rd_arbiter
   import cpu_rd_pkg::*;
#(
   parameter int                 N_REQ          = DEF_N_REQ,
   parameter int                 WAIT_CYCLES    = DEF_WAIT_CYCLES,
   parameter int                 TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter logic [N_REQ-1:0]   SLOW_MASK      = '0,
   parameter int                 DEFAULT_IDX    = N_REQ - 1
) (
   input  logic                       pll0_250MHz,
   input  logic                       reset,
   input  logic                       z80Read,
   input  logic [N_REQ-1:0]           rd_req,
   input  logic [N_REQ-1:0]           dev_ready,
   output logic [$clog2(N_REQ)-1:0]   grant_idx,
   output logic                       grant_valid,
   output logic                       cpu_wait_n,
   output logic                       rd_done,
   output logic                       timeout_pulse
`ifdef CPU_RD_CONFLICT_LOG_EN
   ,
   output logic                       conflict_sticky
`endif
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int WCW   = cntWidth(WAIT_CYCLES);
   localparam int TCW   = cntWidth(TIMEOUT_CYCLES);

   rdState_e         state;
   logic [WCW-1:0]   waitCnt, waitNext;
   logic [TCW-1:0]   toCnt, toNext;
   logic [IDX_W-1:0] encIdx, selIdx;
   logic             encAny, selSlow, selReady;

   prio_enc #(.N(N_REQ)) uPrio (
      .req (rd_req),
      .idx (encIdx),
      .any (encAny)
   );

   assign selIdx   = encAny ? encIdx : IDX_W'(DEFAULT_IDX);
   assign selSlow  = SLOW_MASK[selIdx];
   assign selReady = dev_ready[selIdx];

   // Next counter values; the exit test looks at the value this cycle leaves behind,
   // so a load of WAIT_CYCLES yields exactly that many WAIT cycles.
   assign waitNext = (waitCnt == '0) ? '0 : waitCnt - 1'b1;
   assign toNext   = (toCnt == '0) ? '0 : toCnt - 1'b1;

   always_ff @(posedge pll0_250MHz) begin
      if (reset) begin
         state         <= IDLE;
         grant_idx     <= IDX_W'(DEFAULT_IDX);
         grant_valid   <= 1'b0;
         cpu_wait_n    <= 1'b1;
         rd_done       <= 1'b0;
         timeout_pulse <= 1'b0;
         waitCnt       <= '0;
         toCnt         <= '0;
      end else begin
         rd_done       <= 1'b0;
         timeout_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (z80Read) begin
                  grant_idx <= selIdx;
                  if (selSlow || !selReady) begin
                     state      <= WAIT;
                     cpu_wait_n <= 1'b0;
                     waitCnt    <= selSlow ? WCW'(WAIT_CYCLES) : '0;
                     toCnt      <= TCW'(TIMEOUT_CYCLES);
                  end else begin
                     state       <= HOLD;
                     grant_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               waitCnt <= waitNext;
               toCnt   <= toNext;
               if (!z80Read) begin
                  state      <= IDLE;
                  cpu_wait_n <= 1'b1;
               end else if (waitNext == '0 && dev_ready[grant_idx]) begin
                  state       <= HOLD;
                  cpu_wait_n  <= 1'b1;
                  grant_valid <= 1'b1;
               end else if (toNext == '0) begin
                  // Forced completion: the CPU reads whatever the mux presents.
                  state         <= HOLD;
                  cpu_wait_n    <= 1'b1;
                  grant_valid   <= 1'b1;
                  timeout_pulse <= 1'b1;
               end
            end
            HOLD: begin
               if (!z80Read) begin
                  state       <= RELEASE;
                  grant_valid <= 1'b0;
                  rd_done     <= 1'b1;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CPU_RD_CONFLICT_LOG_EN
   always_ff @(posedge pll0_250MHz) begin
      if (reset)
         conflict_sticky <= 1'b0;
      else if (state == IDLE && z80Read && ((rd_req & (rd_req - 1'b1)) != '0))
         conflict_sticky <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_cpu_rd_arbiter.sv
// Directed bench for cpu_rd_arbiter with one slow requester (3) and a short timeout.
module tb_cpu_rd_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        z80Read;
   logic [15:0] rdReq;
   logic [15:0] devReady;
   logic [3:0]  grantIdx;
   logic        grantValid, cpuWaitN, rdDone, timeoutPulse;
`ifdef CPU_RD_CONFLICT_LOG_EN
   logic        conflictSticky;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cpu_rd_arbiter #(
      .N_REQ(16), .WAIT_CYCLES(4), .TIMEOUT_CYCLES(10),
      .SLOW_MASK(16'h0008), .DEFAULT_IDX(15)
   ) dut (
      .pll0_250MHz   (clk),
      .reset         (reset),
      .z80Read       (z80Read),
      .rd_req        (rdReq),
      .dev_ready     (devReady),
      .grant_idx     (grantIdx),
      .grant_valid   (grantValid),
      .cpu_wait_n    (cpuWaitN),
      .rd_done       (rdDone),
      .timeout_pulse (timeoutPulse)
`ifdef CPU_RD_CONFLICT_LOG_EN
      ,
      .conflict_sticky (conflictSticky)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; z80Read = 1'b0; rdReq = '0; devReady = '1;
      tick(); tick();
      vectors++;
      if ({grantIdx, grantValid, cpuWaitN, rdDone, timeoutPulse} !== {4'd15, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got idx=%0d gv=%b wn=%b done=%b to=%b, expected idx=15 gv=0 wn=1 done=0 to=0",
                  grantIdx, grantValid, cpuWaitN, rdDone, timeoutPulse);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fast_read();
      rdReq = 16'h0012; devReady = '1; z80Read = 1'b1;
      tick();
      vectors++;
      if ({grantIdx, grantValid, cpuWaitN} !== {4'd1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL fast_grant: got idx=%0d gv=%b wn=%b, expected idx=1 gv=1 wn=1", grantIdx, grantValid, cpuWaitN);
      end
      rdReq = 16'h0001;  // grant must stay frozen while held
      repeat (5) tick();
      vectors++;
      if ({grantIdx, grantValid} !== {4'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL hold_freeze: got idx=%0d gv=%b, expected idx=1 gv=1", grantIdx, grantValid);
      end
      z80Read = 1'b0;
      tick();
      vectors++;
      if ({rdDone, grantValid} !== 2'b10) begin
         miscompares++;
         $display("FAIL release_pulse: got done=%b gv=%b, expected done=1 gv=0", rdDone, grantValid);
      end
      tick();
      vectors++;
      if (rdDone !== 1'b0) begin
         miscompares++;
         $display("FAIL done_one_cycle: got done=%b, expected 0", rdDone);
      end
   endtask

   task automatic test_slow_wait();
      int lowCycles = 0;
      rdReq = 16'h0008; devReady = '1; z80Read = 1'b1;
      tick();
      while (cpuWaitN === 1'b0 && lowCycles < 20) begin
         lowCycles++;
         tick();
      end
      vectors++;
      if (lowCycles !== 4) begin
         miscompares++;
         $display("FAIL slow_wait_len: got %0d low cycles, expected 4", lowCycles);
      end
      vectors++;
      if ({grantIdx, grantValid} !== {4'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL slow_grant: got idx=%0d gv=%b, expected idx=3 gv=1", grantIdx, grantValid);
      end
      z80Read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_timeout();
      int waitCycles = 0;
      rdReq = 16'h0004; devReady = 16'hFFFB; z80Read = 1'b1;
      tick();
      while (cpuWaitN === 1'b0 && timeoutPulse === 1'b0 && waitCycles < 30) begin
         waitCycles++;
         tick();
      end
      vectors++;
      if (waitCycles !== 10) begin
         miscompares++;
         $display("FAIL timeout_len: got %0d wait cycles, expected 10", waitCycles);
      end
      vectors++;
      if ({timeoutPulse, grantValid, cpuWaitN, grantIdx} !== {1'b1, 1'b1, 1'b1, 4'd2}) begin
         miscompares++;
         $display("FAIL timeout_hold: got to=%b gv=%b wn=%b idx=%0d, expected to=1 gv=1 wn=1 idx=2",
                  timeoutPulse, grantValid, cpuWaitN, grantIdx);
      end
      tick();
      vectors++;
      if ({timeoutPulse, grantValid} !== 2'b01) begin
         miscompares++;
         $display("FAIL timeout_one_cycle: got to=%b gv=%b, expected to=0 gv=1", timeoutPulse, grantValid);
      end
      z80Read = 1'b0; devReady = '1;
      tick(); tick();
   endtask

   task automatic test_abort();
      bit sawDone = 1'b0;
      rdReq = 16'h0008; devReady = '1; z80Read = 1'b1;
      tick();
      tick();
      vectors++;
      if (cpuWaitN !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_in_wait: got wn=%b, expected 0", cpuWaitN);
      end
      z80Read = 1'b0;
      tick();
      sawDone = rdDone;
      vectors++;
      if ({cpuWaitN, grantValid} !== 2'b10) begin
         miscompares++;
         $display("FAIL abort_idle: got wn=%b gv=%b, expected wn=1 gv=0", cpuWaitN, grantValid);
      end
      repeat (3) begin
         tick();
         sawDone |= rdDone;
      end
      vectors++;
      if (sawDone !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_no_done: got done seen=%b, expected 0", sawDone);
      end
   endtask

   task automatic test_default_grant();
      rdReq = '0; devReady = '1; z80Read = 1'b1;
      tick();
      vectors++;
      if ({grantIdx, grantValid} !== {4'd15, 1'b1}) begin
         miscompares++;
         $display("FAIL default_grant: got idx=%0d gv=%b, expected idx=15 gv=1", grantIdx, grantValid);
      end
      z80Read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      rdReq = 16'h0001; devReady = '1; z80Read = 1'b1;
      tick();
      z80Read = 1'b0;
      tick();
      z80Read = 1'b1;
      tick();
      vectors++;
      if ({grantValid, rdDone} !== 2'b00) begin
         miscompares++;
         $display("FAIL b2b_idle_gap: got gv=%b done=%b, expected gv=0 done=0", grantValid, rdDone);
      end
      tick();
      vectors++;
      if ({grantIdx, grantValid} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL b2b_regrant: got idx=%0d gv=%b, expected idx=0 gv=1", grantIdx, grantValid);
      end
      z80Read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_hold_wait();
      rdReq = 16'h0002; devReady = '1; z80Read = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      vectors++;
      if ({grantValid, cpuWaitN, rdDone, timeoutPulse, grantIdx} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd15}) begin
         miscompares++;
         $display("FAIL reset_in_hold: got gv=%b wn=%b done=%b to=%b idx=%0d, expected gv=0 wn=1 done=0 to=0 idx=15",
                  grantValid, cpuWaitN, rdDone, timeoutPulse, grantIdx);
      end
      reset = 1'b0; rdReq = 16'h0008;
      tick(); tick();
      reset = 1'b1;
      tick();
      vectors++;
      if ({grantValid, cpuWaitN, rdDone, timeoutPulse} !== 4'b0100) begin
         miscompares++;
         $display("FAIL reset_in_wait: got gv=%b wn=%b done=%b to=%b, expected gv=0 wn=1 done=0 to=0",
                  grantValid, cpuWaitN, rdDone, timeoutPulse);
      end
      reset = 1'b0; z80Read = 1'b0;
      tick();
   endtask

`ifdef CPU_RD_CONFLICT_LOG_EN
   task automatic test_conflict();
      vectors++;
      if (conflictSticky !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_clear: got %b, expected 0", conflictSticky);
      end
      rdReq = 16'h0005; devReady = '1; z80Read = 1'b1;
      tick();
      vectors++;
      if ({conflictSticky, grantIdx} !== {1'b1, 4'd0}) begin
         miscompares++;
         $display("FAIL conflict_set: got sticky=%b idx=%0d, expected sticky=1 idx=0", conflictSticky, grantIdx);
      end
      z80Read = 1'b0; rdReq = '0;
      repeat (3) tick();
      vectors++;
      if (conflictSticky !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_sticky: got %b, expected 1", conflictSticky);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (conflictSticky !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_reset: got %b, expected 0", conflictSticky);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_fast_read();
      test_slow_wait();
      test_timeout();
      test_abort();
      test_default_grant();
      test_back_to_back();
      test_reset_hold_wait();
`ifdef CPU_RD_CONFLICT_LOG_EN
      test_conflict();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_rd_arbiter.md
CPU_RD_ARBITER -- requirements
Module: cpu_rd_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 16, meaning number of read requesters (chip selects).
REQ-002 SHALL have parameter WAIT_CYCLES, default 4, meaning minimum Z80 wait cycles for requesters marked slow.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum cycles in WAIT before forced completion.
REQ-004 SHALL have parameter SLOW_MASK, default all-zero, meaning one bit per requester; 1 means wait states are inserted.
REQ-005 SHALL have parameter DEFAULT_IDX, default N_REQ-1, meaning grant index used when z80Read is high with no request (S100 bus fallback).
REQ-006 SHALL have port pll0_250MHz, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port z80Read, input, 1 bit, CPU read cycle active.
REQ-009 SHALL have port rd_req, input, N_REQ bits, decoded chip selects; bit 0 is highest priority.
REQ-010 SHALL have port dev_ready, input, N_REQ bits, per-device data-valid.
REQ-011 SHALL have port grant_idx, output, clog2(N_REQ) bits, data-in mux select.
REQ-012 SHALL have port grant_valid, output, 1 bit, grant_idx is stable and the mux output may be sampled.
REQ-013 SHALL have port cpu_wait_n, output, 1 bit, active-low Z80 WAIT.
REQ-014 SHALL have port rd_done, output, 1 bit, one-cycle pulse at the end of each completed read.
REQ-015 SHALL have port timeout_pulse, output, 1 bit, one-cycle pulse when a WAIT times out.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT, HOLD and RELEASE.
REQ-017 In IDLE with z80Read=1, SHALL latch the lowest set index of rd_req into grant_idx, or DEFAULT_IDX if rd_req=0, on the same clock edge.
REQ-018 From IDLE, SHALL go to WAIT if the granted bit is set in SLOW_MASK or dev_ready[grant] is 0; otherwise SHALL go to HOLD.
REQ-019 On WAIT entry, SHALL load the wait counter with WAIT_CYCLES (0 if not slow) and the timeout counter with TIMEOUT_CYCLES; cpu_wait_n=0 throughout WAIT.
REQ-020 SHALL leave WAIT for HOLD when the wait counter is 0 and dev_ready[grant]=1, or when the timeout counter reaches 0 (timeout_pulse=1 for that cycle).
REQ-021 Counters SHALL saturate at 0 and never wrap.
REQ-022 In HOLD, SHALL drive grant_valid=1 and cpu_wait_n=1, and SHALL freeze grant_idx regardless of rd_req changes.
REQ-023 In HOLD, when z80Read=0, SHALL go to RELEASE.
REQ-024 In RELEASE, SHALL drive rd_done=1 and grant_valid=0 for one cycle, then go to IDLE.
REQ-025 If z80Read falls during WAIT, SHALL abort to IDLE with cpu_wait_n=1 and no rd_done.
REQ-026 Multiple simultaneous rd_req bits SHALL resolve by fixed priority with no starvation protection.
REQ-027 Back-to-back reads SHALL incur a minimum of one IDLE cycle between RELEASE and the next grant.

Reset
REQ-028 On reset=1 at a clock edge, SHALL enter IDLE with grant_idx=DEFAULT_IDX, grant_valid=0, cpu_wait_n=1, rd_done=0, timeout_pulse=0 and counters=0.
REQ-029 Reset SHALL override all states, including mid-WAIT and mid-HOLD, and SHALL emit no pulse.

Configuration
REQ-030 SHALL support the macro CPU_RD_CONFLICT_LOG_EN.
REQ-031 When the macro is defined, SHALL add output conflict_sticky (1 bit), set whenever a grant is latched with more than one rd_req bit high, and cleared only by reset.
REQ-032 When the macro is undefined, the port and its logic SHALL be absent, with no other behavioural change.

Structure
REQ-033 SHALL place the FSM state enum and a default-parameter constant set in a shared package cpu_rd_pkg.
REQ-034 SHALL use one sub-module, prio_enc (N_REQ to index plus any flag), for the priority encoder.

Verification
REQ-035 Bench SHALL cover: rd_req=16'h0012, z80Read 1 for 6 cycles, dev_ready all 1 -> grant_idx=1, HOLD next cycle, rd_done one cycle after z80Read falls.
REQ-036 Bench SHALL cover: SLOW_MASK bit 3 set, rd_req=16'h0008 -> cpu_wait_n low for exactly 4 cycles, then grant_valid=1.
REQ-037 Bench SHALL cover: dev_ready[2] held 0, TIMEOUT_CYCLES=10 -> timeout_pulse after 10 WAIT cycles, HOLD entered.
REQ-038 Bench SHALL cover: z80Read dropped in the 2nd WAIT cycle -> IDLE, cpu_wait_n=1, no rd_done.
REQ-039 Bench SHALL cover: z80Read=1 with rd_req=0 -> grant_idx=15, grant_valid=1.
REQ-040 Bench SHALL cover: reset asserted in HOLD -> next cycle grant_valid=0, cpu_wait_n=1; with CPU_RD_CONFLICT_LOG_EN, rd_req=16'h0005 -> conflict_sticky=1 until reset.
